// File: rtl/vc_input_unit.sv
// Virtual-channel input unit: per-VC circular FIFOs with round-robin VC
// selection, optional packet locking and per-VC credit return.
module vc_input_unit #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_VC      = 2,
    parameter int unsigned VC_DEPTH    = 4,
    parameter int unsigned VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter bit          LOCK_PACKET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_flit,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    output logic [DATA_W-1:0] out_flit,
    output logic              out_valid,
    output logic [VC_W-1:0]   out_vc,
    input  logic              out_ready,
    output logic [NUM_VC-1:0] vc_status,
    output logic [NUM_VC-1:0] credit_out,
    output logic              err
);

    localparam int unsigned PTR_W   = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(VC_DEPTH + 1);
    localparam logic [1:0]  FT_HEAD = 2'b01;
    localparam logic [1:0]  FT_TAIL = 2'b10;

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_e;

    logic [DATA_W-1:0] mem [NUM_VC][VC_DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_nxt [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_nxt [NUM_VC];
    logic [CNT_W-1:0]  count [NUM_VC];
    logic [CNT_W-1:0]  count_nxt [NUM_VC];

    lock_state_e       state, state_nxt;
    logic [VC_W-1:0]   lock_vc, lock_vc_nxt;
    logic [VC_W-1:0]   rr, rr_nxt;
    logic [NUM_VC-1:0] status_q, status_nxt;
    logic [NUM_VC-1:0] credit_q, credit_nxt;
    logic              err_q, err_nxt;

    logic              sel_valid;
    logic [VC_W-1:0]   sel_vc;
    logic [DATA_W-1:0] head_flit;
    logic [1:0]        head_type;
    logic              deq;
    logic              wr_en;
    logic              in_range;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(VC_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [VC_W-1:0] inc_vc(input logic [VC_W-1:0] v);
        return (v == VC_W'(NUM_VC - 1)) ? '0 : v + VC_W'(1);
    endfunction

    // Eligible VC: the locked one, else first non-empty scanning up from rr
    always_comb begin
        int unsigned j;
        sel_valid = 1'b0;
        sel_vc    = '0;
        j         = 0;
        if (state == ST_LOCKED) begin
            sel_valid = (count[lock_vc] != '0);
            sel_vc    = lock_vc;
        end else begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                j = 32'(rr) + i;
                if (j >= NUM_VC) j = j - NUM_VC;
                if (!sel_valid && count[VC_W'(j)] != '0) begin
                    sel_valid = 1'b1;
                    sel_vc    = VC_W'(j);
                end
            end
        end
    end

    assign head_flit  = sel_valid ? mem[sel_vc][rd_ptr[sel_vc]] : '0;
    assign head_type  = head_flit[DATA_W-1 -: 2];
    assign out_flit   = head_flit;
    assign out_valid  = sel_valid;
    assign out_vc     = sel_valid ? sel_vc : '0;
    assign vc_status  = status_q;
    assign credit_out = credit_q;
    assign err        = err_q;

    assign deq      = sel_valid && out_ready;
    assign in_range = (32'(in_vc) < NUM_VC);

    always_comb begin
        rd_ptr_nxt  = rd_ptr;
        wr_ptr_nxt  = wr_ptr;
        count_nxt   = count;
        state_nxt   = state;
        lock_vc_nxt = lock_vc;
        rr_nxt      = rr;
        credit_nxt  = '0;
        err_nxt     = err_q;
        wr_en       = 1'b0;
        status_nxt  = '0;

        if (deq) begin
            rd_ptr_nxt[sel_vc] = inc_ptr(rd_ptr[sel_vc]);
            count_nxt[sel_vc]  = count[sel_vc] - CNT_W'(1);
            credit_nxt[sel_vc] = 1'b1;
            if (state == ST_UNLOCKED) begin
                rr_nxt = inc_vc(sel_vc);
                if (LOCK_PACKET && head_type == FT_HEAD) begin
                    state_nxt   = ST_LOCKED;
                    lock_vc_nxt = sel_vc;
                end
            end else if (head_type == FT_TAIL) begin
                state_nxt = ST_UNLOCKED;
                rr_nxt    = inc_vc(lock_vc);
            end
        end

        // A full VC still accepts a write when the same edge dequeues from it
        if (in_valid) begin
            if (!in_range) begin
                err_nxt = 1'b1;
            end else if (32'(count[in_vc]) < VC_DEPTH || (deq && sel_vc == in_vc)) begin
                wr_en             = 1'b1;
                wr_ptr_nxt[in_vc] = inc_ptr(wr_ptr[in_vc]);
                count_nxt[in_vc]  = count_nxt[in_vc] + CNT_W'(1);
            end else begin
                err_nxt = 1'b1;
            end
        end

        for (int unsigned k = 0; k < NUM_VC; k++) begin
            status_nxt[k] = (count_nxt[k] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_VC; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                count[k]  <= '0;
            end
            state    <= ST_UNLOCKED;
            lock_vc  <= '0;
            rr       <= '0;
            status_q <= '0;
            credit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
            state    <= state_nxt;
            lock_vc  <= lock_vc_nxt;
            rr       <= rr_nxt;
            status_q <= status_nxt;
            credit_q <= credit_nxt;
            err_q    <= err_nxt;
        end
    end

    // Flit storage needs no reset; reads are gated by the counts
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[in_vc][wr_ptr[in_vc]] <= in_flit;
        end
    end

endmodule

// File: doc/vc_input_unit.md
Name: vc_input_unit

Overview:
Parametrised virtual-channel input unit for the mesh router. It replaces the fixed 2-VC input buffer and is instantiated once per router input port (north/east/south/west/local). It stores incoming flits in per-VC circular FIFOs and selects one VC per cycle by round-robin, with optional packet locking. It presents the selected flit to the crossbar allocator/switch and returns per-VC credits upstream.

Parameters:
DATA_W, 64, flit width; bits [DATA_W-1:DATA_W-2] are the flit type: 00 body, 01 head, 10 tail, 11 single (head+tail).
NUM_VC, 2, number of virtual channels, 1..8.
VC_DEPTH, 4, flits per VC FIFO, 2..16; need not be a power of 2.
VC_W, max(1,clog2(NUM_VC)), VC index width.
LOCK_PACKET, 1, 1 = output held on one VC from head to tail; 0 = re-arbitrate every flit.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_flit  in  DATA_W  incoming flit
in_valid  in  1  in_flit valid this cycle
in_vc  in  VC_W  target VC of in_flit
out_flit  out  DATA_W  flit at the head of the selected VC; 0 when out_valid=0
out_valid  out  1  out_flit valid (crossbar request)
out_vc  out  VC_W  VC of out_flit; 0 when out_valid=0
out_ready  in  1  crossbar grant; dequeues when out_valid && out_ready
vc_status  out  NUM_VC  bit k = VC k non-empty
credit_out  out  NUM_VC  one-cycle pulse, bit k = one slot freed in VC k
err  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at an edge):
  - All read/write pointers and counts cleared to 0; all VC FIFOs empty.
  - Lock cleared; round-robin pointer rr=0.
  - Outputs: out_valid=0, out_flit=0, out_vc=0, vc_status=0, credit_out=0, err=0.
  - Reset mid-packet discards all stored flits and issues no credits.
- Write:
  - in_valid=1 with in_vc<NUM_VC and count[in_vc]<VC_DEPTH: flit stored at wr_ptr, wr_ptr wraps VC_DEPTH-1 -> 0, count+1.
  - Write into a full VC: flit dropped, err set.
  - Write with in_vc>=NUM_VC: flit dropped, err set.
  - Simultaneous write and dequeue on a full VC: the write is accepted and count is unchanged.
- Show-ahead read: a flit written at edge t is visible on out_* after edge t (1-cycle latency). Out_* are combinational from registered FIFO/arbiter state; no combinational in->out path.
- Selection:
  - Unlocked: the eligible VC is the first non-empty VC found scanning from rr upward with wrap.
  - Locked: only the locked VC is eligible. If it is empty, out_valid=0 (bubble); other VCs are not served.
- Dequeue (out_valid && out_ready at an edge): rd_ptr advances with wrap, count-1. credit_out[out_vc] pulses high for the following cycle only.
- Per-VC lock FSM (LOCK_PACKET=1): states UNLOCKED, LOCKED(k).
  - UNLOCKED -> LOCKED(k): on dequeue of a head flit (01) from VC k.
  - LOCKED(k) -> UNLOCKED: on dequeue of a tail flit (10) from VC k.
  - A single flit (11) or body flit (00) in UNLOCKED leaves the state unchanged.
  - rr <- (k+1) mod NUM_VC on leaving LOCKED, or on dequeue while UNLOCKED.
- LOCK_PACKET=0: no lock; rr <- (out_vc+1) mod NUM_VC after every dequeue.
- vc_status[k] = (count[k]!=0), registered state.
- err clears only on reset.
- NUM_VC=1: out_vc is 0 and round-robin is trivial.

Test Plan:
- Reset, then write a single flit 0x4000_0000_0000_0001 on VC1 -> next cycle out_valid=1, out_vc=1, vc_status=2'b10; dequeue with out_ready=1 -> credit_out=2'b10 for exactly one cycle, vc_status=0.
- Fill VC0 with 4 flits (VC_DEPTH=4), write a 5th -> 5th dropped, err=1 and stays 1; drain -> exactly 4 flits out, in order, 4 credit pulses on bit 0.
- LOCK_PACKET=1: VC0 holds head, body, body, tail; VC1 holds single; out_ready=1 throughout -> output order is VC0×4 then VC1; no VC1 flit before the VC0 tail.
- LOCK_PACKET=0: same stimulus -> outputs alternate VC0, VC1, VC0, VC0, VC0 (rr rotation).
- Locked VC0 has delivered the head; the rest of its packet arrives 3 cycles later while VC1 is non-empty -> out_valid=0 for those cycles, VC1 not served until the VC0 tail.
- Full VC0 with a simultaneous write and dequeue -> count stays 4, err stays 0; assert rst mid-packet -> all outputs 0 on the next cycle, no credit pulses.
